// File: rtl/i2c_seq_pkg.sv
// Shared constants and state encoding for the I2C register sequencer.
// Register map and command bytes follow the OpenCores i2c_master_top layout.
package i2c_seq_pkg;

  localparam logic [2:0] PRER_LO = 3'd0;
  localparam logic [2:0] PRER_HI = 3'd1;
  localparam logic [2:0] CTR     = 3'd2;
  localparam logic [2:0] TXR_RXR = 3'd3;
  localparam logic [2:0] CR_SR   = 3'd4;

  localparam logic [7:0] CTR_EN      = 8'h80;
  localparam logic [7:0] STA_WR      = 8'h90;
  localparam logic [7:0] WR          = 8'h10;
  localparam logic [7:0] STO_WR      = 8'h50;
  localparam logic [7:0] RD_NACK_STO = 8'h68;
  localparam logic [7:0] STO         = 8'h40;

  localparam int SR_TIP   = 1;
  localparam int SR_RXACK = 7;

  typedef enum logic [3:0] {
    INIT, IDLE, TXR, CMD, GAP, POLL, CHECK, RXR, ABORT, RESP
  } seq_state_t;

endpackage

// File: rtl/i2c_reg_seq_if.sv
// Request/response handshake between a register client and the I2C sequencer.
interface i2c_reg_seq_if;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_rd_i;
  logic [6:0] req_dev_i;
  logic [7:0] req_reg_i;
  logic [7:0] req_wdat_i;
  logic       rsp_valid_o;
  logic [7:0] rsp_rdat_o;
  logic       rsp_nack_o;
  logic       rsp_tout_o;

  modport master (
    output req_valid_i, req_rd_i, req_dev_i, req_reg_i, req_wdat_i,
    input  req_ready_o, rsp_valid_o, rsp_rdat_o, rsp_nack_o, rsp_tout_o
  );

  modport slave (
    input  req_valid_i, req_rd_i, req_dev_i, req_reg_i, req_wdat_i,
    output req_ready_o, rsp_valid_o, rsp_rdat_o, rsp_nack_o, rsp_tout_o
  );
endinterface

// File: rtl/i2c_wbm_access.sv
// Single Wishbone access engine: one start pulse gives one bus cycle and a done pulse.
// cyc/stb are always low on the cycle done is reported, so back-to-back accesses get a gap.
module i2c_wbm_access (
  input  logic       wb_clk_i,
  input  logic       rst_i,
  input  logic       start,
  input  logic [2:0] adr,
  input  logic       we,
  input  logic [7:0] dat,
  output logic       done,
  output logic [7:0] rdat,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic       wbm_ack_i
);

  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      done      <= 1'b0;
      rdat      <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_we_o  <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_cyc_o <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wbm_cyc_o) begin
        if (wbm_ack_i) begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          wbm_we_o  <= 1'b0;
          rdat      <= wbm_dat_i;
          done      <= 1'b1;
        end
      end else if (start) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_adr_o <= adr;
        wbm_we_o  <= we;
        wbm_dat_o <= dat;
      end
    end
  end

endmodule

// File: rtl/i2c_reg_seq.sv
// Register-level I2C sequencer: turns single register read/write requests into
// the TXR/CR/SR access sequence of an i2c_master_top core.
module i2c_reg_seq
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE = 16'd99,
  parameter int          POLL_MAX = 4095
) (
  input  logic         wb_clk_i,
  input  logic         rst_i,
  i2c_reg_seq_if.slave req,
  output logic [2:0]   wbm_adr_o,
  output logic [7:0]   wbm_dat_o,
  input  logic [7:0]   wbm_dat_i,
  output logic         wbm_we_o,
  output logic         wbm_stb_o,
  output logic         wbm_cyc_o,
  input  logic         wbm_ack_i
);

  localparam logic [11:0] POLL_LAST = 12'(POLL_MAX);

  seq_state_t  state;
  logic [1:0]  step;
  logic [11:0] poll_cnt;
  logic        gap_cnt, acc_wait, acc_start, acc_done, aborting, rxack_q;
  logic [7:0]  acc_rdat;
  logic        cap_rd;
  logic [6:0]  cap_dev;
  logic [7:0]  cap_reg, cap_wdat;
  logic        ready_q, rsp_valid_q, rsp_nack_q, rsp_tout_q;
  logic [7:0]  rsp_rdat_q;
  logic [2:0]  acc_adr;
  logic        acc_we, acc_state;
  logic [7:0]  acc_dat, tx_byte, cmd_byte;

  assign req.req_ready_o = ready_q;
  assign req.rsp_valid_o = rsp_valid_q;
  assign req.rsp_rdat_o  = rsp_rdat_q;
  assign req.rsp_nack_o  = rsp_nack_q;
  assign req.rsp_tout_o  = rsp_tout_q;

  // Address/data of the access owned by the current state; step 2 is the
  // repeated-start address for reads and the data byte for writes.
  always_comb begin
    tx_byte   = '0;
    cmd_byte  = STA_WR;
    acc_adr   = CR_SR;
    acc_we    = 1'b0;
    acc_dat   = '0;
    acc_state = 1'b0;
    case (step)
      2'd0: begin tx_byte = {cap_dev, 1'b0}; cmd_byte = STA_WR; end
      2'd1: begin tx_byte = cap_reg;         cmd_byte = WR;     end
      2'd2: begin
        tx_byte  = cap_rd ? {cap_dev, 1'b1} : cap_wdat;
        cmd_byte = cap_rd ? STA_WR : STO_WR;
      end
      default: begin tx_byte = '0; cmd_byte = RD_NACK_STO; end
    endcase
    case (state)
      INIT: begin
        acc_state = 1'b1;
        acc_we    = 1'b1;
        acc_adr   = {1'b0, step};
        case (step)
          2'd0:    acc_dat = PRESCALE[7:0];
          2'd1:    acc_dat = PRESCALE[15:8];
          default: acc_dat = CTR_EN;
        endcase
      end
      TXR:     begin acc_state = 1'b1; acc_we = 1'b1; acc_adr = TXR_RXR; acc_dat = tx_byte;  end
      CMD:     begin acc_state = 1'b1; acc_we = 1'b1; acc_adr = CR_SR;   acc_dat = cmd_byte; end
      ABORT:   begin acc_state = 1'b1; acc_we = 1'b1; acc_adr = CR_SR;   acc_dat = STO;      end
      POLL:    begin acc_state = 1'b1; acc_adr = CR_SR;   end
      RXR:     begin acc_state = 1'b1; acc_adr = TXR_RXR; end
      default: acc_state = 1'b0;
    endcase
  end

  i2c_wbm_access u_access (
    .wb_clk_i  (wb_clk_i),
    .rst_i     (rst_i),
    .start     (acc_start),
    .adr       (acc_adr),
    .we        (acc_we),
    .dat       (acc_dat),
    .done      (acc_done),
    .rdat      (acc_rdat),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_we_o  (wbm_we_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_ack_i (wbm_ack_i)
  );

  // Every bus-owning state fires one access on entry and advances on its done pulse.
  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= INIT;
      step        <= '0;
      poll_cnt    <= '0;
      gap_cnt     <= 1'b0;
      acc_wait    <= 1'b0;
      acc_start   <= 1'b0;
      aborting    <= 1'b0;
      rxack_q     <= 1'b0;
      cap_rd      <= 1'b0;
      cap_dev     <= '0;
      cap_reg     <= '0;
      cap_wdat    <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_nack_q  <= 1'b0;
      rsp_tout_q  <= 1'b0;
      rsp_rdat_q  <= '0;
    end else begin
      acc_start   <= 1'b0;
      rsp_valid_q <= 1'b0;
      if (acc_state && !acc_wait) begin
        acc_start <= 1'b1;
        acc_wait  <= 1'b1;
      end
      if (acc_done) acc_wait <= 1'b0;

      case (state)
        INIT: if (acc_done) begin
          if (step == 2'd2) begin
            step    <= '0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            step <= step + 2'd1;
          end
        end
        IDLE: if (req.req_valid_i && ready_q) begin
          cap_rd   <= req.req_rd_i;
          cap_dev  <= req.req_dev_i;
          cap_reg  <= req.req_reg_i;
          cap_wdat <= req.req_wdat_i;
          ready_q  <= 1'b0;
          step     <= '0;
          aborting <= 1'b0;
          state    <= TXR;
        end
        TXR: if (acc_done) state <= CMD;
        CMD, ABORT: begin
          poll_cnt <= '0;
          if (acc_done) begin
            gap_cnt <= 1'b0;
            if (state == ABORT) aborting <= 1'b1;
            state <= GAP;
          end
        end
        GAP: begin
          gap_cnt <= 1'b1;
          if (gap_cnt) state <= POLL;
        end
        POLL: if (acc_done) begin
          if (!acc_rdat[SR_TIP]) begin
            rxack_q <= acc_rdat[SR_RXACK];
            state   <= CHECK;
          end else if (poll_cnt == POLL_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_rdat_q  <= '0;
            rsp_nack_q  <= 1'b0;
            rsp_tout_q  <= 1'b1;
            state       <= RESP;
          end else begin
            poll_cnt <= poll_cnt + 12'd1;
          end
        end
        // The final read byte always ends in a master NACK, so its RxACK is ignored.
        CHECK: begin
          if (aborting || (rxack_q && step != 2'd3)) begin
            if (aborting) begin
              rsp_valid_q <= 1'b1;
              rsp_rdat_q  <= '0;
              rsp_nack_q  <= 1'b1;
              rsp_tout_q  <= 1'b0;
              state       <= RESP;
            end else begin
              state <= ABORT;
            end
          end else if (step == 2'd3) begin
            state <= RXR;
          end else if (!cap_rd && step == 2'd2) begin
            rsp_valid_q <= 1'b1;
            rsp_rdat_q  <= '0;
            rsp_nack_q  <= 1'b0;
            rsp_tout_q  <= 1'b0;
            state       <= RESP;
          end else begin
            step  <= step + 2'd1;
            state <= (cap_rd && step == 2'd2) ? CMD : TXR;
          end
        end
        RXR: if (acc_done) begin
          rsp_valid_q <= 1'b1;
          rsp_rdat_q  <= acc_rdat;
          rsp_nack_q  <= 1'b0;
          rsp_tout_q  <= 1'b0;
          state       <= RESP;
        end
        RESP: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Self-checking bench for i2c_reg_seq against a behavioural i2c_master_top register model.
module tb_i2c_reg_seq;

  localparam logic [8:0] NONE = 9'h100;
  localparam int NVEC = 8;

  logic       wb_clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o;
  logic [7:0] wbm_dat_i;
  logic       wbm_we_o, wbm_stb_o, wbm_cyc_o;
  logic       wbm_ack_i;

  i2c_reg_seq_if req_if ();

  i2c_reg_seq #(.PRESCALE(16'd99), .POLL_MAX(15)) dut (
    .wb_clk_i  (wb_clk_i),
    .rst_i     (rst_i),
    .req       (req_if.slave),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_we_o  (wbm_we_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_ack_i (wbm_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Core model configuration
  logic [8:0] cfg_nack = NONE;
  int         cfg_tip = 0;
  logic       cfg_stuck = 1'b0;
  logic [7:0] cfg_rx = 8'h00;

  // Core model state and bus logs
  logic        ack = 1'b0;
  logic        ack_d = 1'b0;
  logic [7:0]  txr_q = 8'h00;
  logic        rxack_m = 1'b0;
  int          tip_left = 0;
  logic [7:0]  txr_log[$];
  logic [7:0]  cr_log[$];
  logic [10:0] init_log[$];
  int          sr_reads = 0;
  int          cyc_viol = 0;
  int          gap_viol = 0;
  logic        in_gap = 1'b0;
  int          gap_len = 0;

  assign wbm_ack_i = ack;

  always_comb begin
    case (wbm_adr_o)
      3'd3:    wbm_dat_i = cfg_rx;
      3'd4:    wbm_dat_i = {rxack_m, 5'b0, (cfg_stuck || tip_left != 0), 1'b0};
      default: wbm_dat_i = 8'h00;
    endcase
  end

  // Registered-ack slave; a CR write arms TIP for cfg_tip reads and sets RxACK.
  always @(posedge wb_clk_i) begin
    ack   <= wbm_cyc_o && wbm_stb_o && !ack;
    ack_d <= ack;
    if (ack_d && wbm_cyc_o) cyc_viol++;
    if (wbm_cyc_o && wbm_stb_o && ack) begin
      if (wbm_we_o) begin
        case (wbm_adr_o)
          3'd3: begin txr_q <= wbm_dat_o; txr_log.push_back(wbm_dat_o); end
          3'd4: begin
            cr_log.push_back(wbm_dat_o);
            tip_left <= cfg_tip;
            if (wbm_dat_o == 8'h68)  rxack_m <= 1'b1;
            else if (wbm_dat_o[4])   rxack_m <= (!cfg_nack[8] && txr_q == cfg_nack[7:0]);
            else                     rxack_m <= 1'b0;
            in_gap  <= 1'b1;
            gap_len <= 0;
          end
          default: init_log.push_back({wbm_adr_o, wbm_dat_o});
        endcase
      end else if (wbm_adr_o == 3'd4) begin
        sr_reads++;
        if (tip_left > 0) tip_left <= tip_left - 1;
      end
    end else if (in_gap) begin
      if (!wbm_cyc_o) gap_len <= gap_len + 1;
      else begin
        if (gap_len < 2) gap_viol++;
        in_gap <= 1'b0;
      end
    end
  end

  typedef struct {
    logic        rd;
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [7:0]  wdat;
    logic [8:0]  nack_byte;
    int          tip;
    logic        stuck;
    logic [7:0]  rx;
    logic [31:0] txr;
    int          ntxr;
    logic [39:0] cr;
    int          ncr;
    int          srrd;
    logic        nack;
    logic        tout;
    logic [7:0]  rdat;
  } vec_t;

  vec_t vec[NVEC];
  int   checks = 0;
  int   failures = 0;
  int   txr_base, cr_base, sr_base, init_base;
  logic rsp_nack_s, rsp_tout_s;
  logic [7:0] rsp_rdat_s;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int i, output int waited);
    cfg_nack  = vec[i].nack_byte;
    cfg_tip   = vec[i].tip;
    cfg_stuck = vec[i].stuck;
    cfg_rx    = vec[i].rx;
    txr_base  = txr_log.size();
    cr_base   = cr_log.size();
    sr_base   = sr_reads;
    waited = 0;
    while (!req_if.req_ready_o && waited < 2000) begin
      @(negedge wb_clk_i);
      waited++;
    end
    checkOutput($sformatf("v%0d_ready_wait", i), 64'(req_if.req_ready_o), 64'(1));
    req_if.req_valid_i = 1'b1;
    req_if.req_rd_i    = vec[i].rd;
    req_if.req_dev_i   = vec[i].dev;
    req_if.req_reg_i   = vec[i].rg;
    req_if.req_wdat_i  = vec[i].wdat;
    @(negedge wb_clk_i);
    req_if.req_valid_i = 1'b0;
    checkOutput($sformatf("v%0d_ready_drop", i), 64'(req_if.req_ready_o), 64'(0));
  endtask

  task automatic waitResponse(input int i);
    int n;
    n = 0;
    while (!req_if.rsp_valid_o && n < 3000) begin
      @(negedge wb_clk_i);
      n++;
    end
    checkOutput($sformatf("v%0d_rsp_seen", i), 64'(req_if.rsp_valid_o), 64'(1));
    rsp_nack_s = req_if.rsp_nack_o;
    rsp_tout_s = req_if.rsp_tout_o;
    rsp_rdat_s = req_if.rsp_rdat_o;
  endtask

  task automatic checkVector(input int i);
    logic [31:0] t;
    logic [39:0] c;
    int nt, nc;
    nt = txr_log.size() - txr_base;
    nc = cr_log.size() - cr_base;
    t = '0;
    c = '0;
    for (int k = 0; k < nt && k < 4; k++) t[31-8*k -: 8] = txr_log[txr_base+k];
    for (int k = 0; k < nc && k < 5; k++) c[39-8*k -: 8] = cr_log[cr_base+k];
    checkOutput($sformatf("v%0d_txr_seq", i), {32'(nt), t}, {32'(vec[i].ntxr), vec[i].txr});
    checkOutput($sformatf("v%0d_cr_seq", i), {24'(nc), c}, {24'(vec[i].ncr), vec[i].cr});
    checkOutput($sformatf("v%0d_sr_reads", i), 64'(sr_reads - sr_base), 64'(vec[i].srrd));
    checkOutput($sformatf("v%0d_nack", i), 64'(rsp_nack_s), 64'(vec[i].nack));
    checkOutput($sformatf("v%0d_tout", i), 64'(rsp_tout_s), 64'(vec[i].tout));
    checkOutput($sformatf("v%0d_rdat", i), 64'(rsp_rdat_s), 64'(vec[i].rdat));
  endtask

  task automatic checkInit(input string name);
    logic [32:0] got;
    int n, cnt;
    n = 0;
    while (!req_if.req_ready_o && n < 500) begin
      @(negedge wb_clk_i);
      n++;
    end
    checkOutput({name, "_ready"}, 64'(req_if.req_ready_o), 64'(1));
    cnt = init_log.size() - init_base;
    got = '0;
    for (int k = 0; k < cnt && k < 3; k++) got[32-11*k -: 11] = init_log[init_base+k];
    checkOutput({name, "_writes"}, {31'(cnt), got}, {31'(3), 11'h063, 11'h100, 11'h280});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    //           rd    dev    reg    wdat   nack    tip stuck rx      txr          n  cr              n  sr  nack  tout  rdat
    vec[0] = '{1'b0, 7'h50, 8'h12, 8'hA5, NONE,   2, 1'b0, 8'h00, 32'hA012A500, 3, 40'h9010500000, 3, 9,  1'b0, 1'b0, 8'h00};
    vec[1] = '{1'b1, 7'h50, 8'h12, 8'h00, NONE,   1, 1'b0, 8'h3C, 32'hA012A100, 3, 40'h9010906800, 4, 8,  1'b0, 1'b0, 8'h3C};
    vec[2] = '{1'b0, 7'h22, 8'h12, 8'hA5, 9'h044, 0, 1'b0, 8'h00, 32'h44000000, 1, 40'h9040000000, 2, 2,  1'b1, 1'b0, 8'h00};
    vec[3] = '{1'b0, 7'h50, 8'h34, 8'h5A, NONE,   0, 1'b0, 8'h00, 32'hA0345A00, 3, 40'h9010500000, 3, 3,  1'b0, 1'b0, 8'h00};
    vec[4] = '{1'b0, 7'h50, 8'h01, 8'h77, 9'h077, 1, 1'b0, 8'h00, 32'hA0017700, 3, 40'h9010504000, 4, 8,  1'b1, 1'b0, 8'h00};
    vec[5] = '{1'b1, 7'h50, 8'h12, 8'h00, 9'h0A1, 0, 1'b0, 8'h3C, 32'hA012A100, 3, 40'h9010904000, 4, 4,  1'b1, 1'b0, 8'h00};
    vec[6] = '{1'b0, 7'h50, 8'h12, 8'hA5, NONE,   0, 1'b1, 8'h00, 32'hA0000000, 1, 40'h9000000000, 1, 16, 1'b0, 1'b1, 8'h00};
    vec[7] = '{1'b1, 7'h50, 8'h80, 8'h00, NONE,   3, 1'b0, 8'hF0, 32'hA080A100, 3, 40'h9010906800, 4, 16, 1'b0, 1'b0, 8'hF0};

    req_if.req_valid_i = 1'b0;
    req_if.req_rd_i    = 1'b0;
    req_if.req_dev_i   = '0;
    req_if.req_reg_i   = '0;
    req_if.req_wdat_i  = '0;

    repeat (3) @(negedge wb_clk_i);
    checkOutput("reset_bus", {61'(0), wbm_cyc_o, wbm_stb_o, wbm_we_o}, 64'(0));
    checkOutput("reset_rsp", {53'(0), req_if.req_ready_o, req_if.rsp_valid_o,
                req_if.rsp_nack_o, req_if.rsp_tout_o, req_if.rsp_rdat_o}, 64'(0));
    init_base = init_log.size();
    rst_i = 1'b1;
    checkInit("init");

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(i, w);
      waitResponse(i);
      checkVector(i);
    end

    // Response is held and a request on the first IDLE cycle is taken at once.
    @(negedge wb_clk_i);
    checkOutput("b2b_valid_pulse", 64'(req_if.rsp_valid_o), 64'(0));
    checkOutput("b2b_rdat_held", 64'(req_if.rsp_rdat_o), 64'(8'hF0));
    checkOutput("b2b_ready", 64'(req_if.req_ready_o), 64'(1));
    applyStimulus(2, w);
    checkOutput("b2b_no_wait", 64'(w), 64'(0));
    waitResponse(2);
    checkVector(2);

    // Reset in the middle of the first CR write of a read.
    applyStimulus(1, w);
    w = 0;
    while (!(wbm_cyc_o && wbm_we_o && wbm_adr_o == 3'd4) && w < 200) begin
      @(negedge wb_clk_i);
      w++;
    end
    checkOutput("midrst_cr_seen", 64'(wbm_cyc_o && wbm_we_o && wbm_adr_o == 3'd4), 64'(1));
    #2 rst_i = 1'b0;
    #1;
    checkOutput("midrst_cyc_drop", {62'(0), wbm_cyc_o, wbm_stb_o}, 64'(0));
    checkOutput("midrst_rsp_clear", {61'(0), req_if.req_ready_o, req_if.rsp_valid_o,
                req_if.rsp_nack_o}, 64'(0));
    repeat (2) @(negedge wb_clk_i);
    init_base = init_log.size();
    rst_i = 1'b1;
    checkInit("reinit");

    applyStimulus(0, w);
    waitResponse(0);
    checkVector(0);

    checkOutput("cyc_low_after_ack", 64'(cyc_viol), 64'(0));
    checkOutput("cmd_to_poll_gap", 64'(gap_viol), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_reg_seq.md
I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 16'd99, meaning the prescale value written to core registers 0 and 1 during initialisation.
REQ-002 The block SHALL have parameter POLL_MAX, default 4095, meaning the maximum number of status polls per byte before a timeout.
REQ-003 wb_clk_i  in  1  clock; all logic SHALL be on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 req_valid_i in 1 request strobe; req_ready_o out 1 request accept; req_rd_i in 1 (1 = register read, 0 = register write).
REQ-006 req_dev_i in 7 slave address; req_reg_i in 8 register address; req_wdat_i in 8 write data.
REQ-007 rsp_valid_o out 1 one-cycle done pulse; rsp_rdat_o out 8 read data; rsp_nack_o out 1 slave NACK; rsp_tout_o out 1 poll timeout.
REQ-008 wbm_adr_o out 3, wbm_dat_o out 8, wbm_dat_i in 8, wbm_we_o out 1, wbm_stb_o out 1, wbm_cyc_o out 1, wbm_ack_i in 1: Wishbone master port to the I2C master core.

Function
REQ-009 A request SHALL be accepted on the cycle where req_valid_i and req_ready_o are both high; req_* SHALL be captured on that cycle.
REQ-010 req_ready_o SHALL be high only in IDLE.
REQ-011 Each Wishbone access SHALL hold cyc=stb=1 until wbm_ack_i is high, complete on that cycle, then drive cyc=stb=0 for at least one cycle.
REQ-012 After reset, the block SHALL perform the writes adr0=PRESCALE[7:0], adr1=PRESCALE[15:8], and adr2=8'h80 (core enable), then enter IDLE.
REQ-013 A byte step SHALL consist of: write TXR (adr3), write CR (adr4) with the command, wait at least 2 idle cycles, then read SR (adr4) until SR[1] (TIP) reads 0.
REQ-014 A write request SHALL run these steps: {dev,0} with CR=8'h90, then reg with CR=8'h10, then wdat with CR=8'h50.
REQ-015 A read request SHALL run these steps: {dev,0} with CR=8'h90, reg with CR=8'h10, {dev,1} with CR=8'h90 (repeated start), then CR=8'h68 without a TXR write, then a read of adr3 into rsp_rdat_o.
REQ-016 After each address or data write step, SR[7]=1 SHALL abort the sequence: the block SHALL write CR=8'h40, poll until TIP=0, and respond with rsp_nack_o=1.
REQ-017 The SR[7] check SHALL NOT apply to the final read byte.
REQ-018 If POLL_MAX+1 consecutive SR reads show TIP=1, the block SHALL respond with rsp_tout_o=1, issue no stop, and return to IDLE.
REQ-019 rsp_valid_o SHALL pulse for one cycle, and rsp_rdat_o/rsp_nack_o/rsp_tout_o SHALL be valid with it and held until the next response.
REQ-020 rsp_rdat_o SHALL be 8'h00 for write requests and for aborted requests.
REQ-021 Return to IDLE SHALL occur on the cycle after rsp_valid_o; a request presented on that cycle SHALL be accepted.
REQ-022 The FSM states SHALL be: INIT, IDLE, TXR, CMD, GAP, POLL, CHECK, RXR, ABORT, RESP.
REQ-023 A 2-bit step counter SHALL select the byte phase, and a 12-bit counter SHALL count polls; the poll counter SHALL clear at every CMD.

Reset
REQ-024 On rst_i low, all outputs SHALL be 0 (req_ready_o=0, wbm_cyc_o=0, rsp_*=0), and the FSM SHALL go to INIT.
REQ-025 Reset asserted mid-access SHALL drop cyc/stb immediately (asynchronously), and initialisation SHALL restart from REQ-012.
REQ-026 No synchronous reset SHALL exist.

Structure
REQ-027 Package i2c_seq_pkg SHALL hold the core register addresses (PRER_LO=0, PRER_HI=1, CTR=2, TXR_RXR=3, CR_SR=4), the CR command constants (STA_WR=8'h90, WR=8'h10, STO_WR=8'h50, RD_NACK_STO=8'h68, STO=8'h40), the SR bit indices, and the state enum.
REQ-028 Sub-module i2c_wbm_access SHALL implement a single Wishbone access (start/adr/we/dat in; done/rdat out) per REQ-011; the sequencer FSM SHALL instantiate it once.

Verification
REQ-029 Bench with i2c_master_top and an I2C slave model at dev 7'h50: after reset, the first three WB writes SHALL be adr0=8'h63, adr1=8'h00, adr2=8'h80, and then req_ready_o=1.
REQ-030 Write request dev=7'h50, reg=8'h12, wdat=8'hA5 -> the slave SHALL see A0,12,A5 then a stop, and the response SHALL be rsp_nack_o=0, rsp_tout_o=0, rsp_rdat_o=8'h00.
REQ-031 Read request dev=7'h50, reg=8'h12, with the slave returning 8'h3C -> the bus SHALL carry A0,12, repeated start, A1, data with a master NACK, then a stop, and rsp_rdat_o SHALL be 8'h3C.
REQ-032 Write request to absent dev 7'h22 -> there SHALL be a NACK after 8'h44, then CR=8'h40, a stop on the bus, and rsp_nack_o=1; the next request SHALL succeed.
REQ-033 SCL held low by the model with POLL_MAX=15 -> after 16 TIP=1 reads, the response SHALL be rsp_tout_o=1.
REQ-034 rst_i pulsed low during the CMD phase of a read -> wbm_cyc_o SHALL be 0 immediately, and initialisation (REQ-012) SHALL repeat.
